// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring shift-subtract unsigned divider. Each quotient bit
// takes two cycles: SHIFT moves the next dividend bit into the partial
// remainder, and SUB conditionally subtracts the divisor and sets that bit.
// A zero divisor bypasses the iteration and reports saturated results.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-high reset
//   start        division request, sampled only in IDLE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   quotient     registered result, held until the next result
//   remainder    registered result, held until the next result
//   busy         high while in SHIFT, SUB or DONE
//   done         one-cycle pulse, results valid
//   div_by_zero  registered flag, updated together with quotient/remainder
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SUB   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_r;
    state_t           next_state_s;

    logic [WIDTH-1:0] a_r;      // dividend being shifted out, quotient shifted in
    logic [WIDTH-1:0] b_r;      // captured divisor
    logic [WIDTH:0]   r_r;      // partial remainder, one spare bit for the shift
    logic [CW-1:0]    cnt_r;    // quotient bits still to produce

    logic             ge_s;
    logic [WIDTH:0]   diff_s;
    logic             last_s;
    logic             zero_div_s;

    assign ge_s       = (r_r >= {1'b0, b_r});
    assign diff_s     = r_r - {1'b0, b_r};
    assign last_s     = (cnt_r == CW'(1));
    assign zero_div_s = (divisor == {WIDTH{1'b0}});

    // Next-state decode for the control FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (zero_div_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = SHIFT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: next_state_s = SUB;
            SUB: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // busy/done are registered from the next state so they track the state
    // register exactly while still coming straight out of flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (next_state_s == DONE);
        end
    end

    // Datapath: operand capture, shift/subtract iteration and result load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            r_r         <= {(WIDTH+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r   <= dividend;
                        b_r   <= divisor;
                        r_r   <= {(WIDTH+1){1'b0}};
                        cnt_r <= CW'(WIDTH);
                        if (zero_div_s) begin
                            quotient    <= {WIDTH{1'b1}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    {r_r, a_r} <= {r_r[WIDTH-1:0], a_r, 1'b0};
                end
                SUB: begin
                    if (ge_s) begin
                        r_r    <= diff_s;
                        a_r[0] <= 1'b1;
                    end
                    cnt_r <= cnt_r - CW'(1);
                    // Results must include this cycle's subtract decision,
                    // so they are formed from the combinational values.
                    if (last_s) begin
                        quotient    <= {a_r[WIDTH-1:1], ge_s};
                        remainder   <= ge_s ? diff_s[WIDTH-1:0] : r_r[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Behavioural reference: plain integer division, saturated on zero divisor.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz, output int lat, output int bc);
        if (b == 0) begin
            q = {W{1'b1}}; r = a; dz = 1'b1; lat = 0; bc = 1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = 2 * W; bc = 2 * W + 1;
        end
    endfunction

    // Stimulus driver: called #1 after a rising edge with the DUT in IDLE.
    // Returns observations; returns #1 after the edge ending the cycle after done.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int bcyc, output bit unstable,
                          output bit done_after);
        logic [W-1:0] q0, r0;
        logic         dz0;
        q0 = quotient; r0 = remainder; dz0 = div_by_zero;
        unstable = 1'b0;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0; bcyc = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== dz0) unstable = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) bcyc++;
        q = quotient; r = remainder; dz = div_by_zero;
        @(posedge clk); #1;
        done_after = done;
        if (quotient !== q || remainder !== r || div_by_zero !== dz) unstable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs: q=%0h r=%0h busy=%0b done=%0b dz=%0b, required all zero",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dz;
    } dcase_t;

    task automatic test_directed();
        dcase_t tbl[7];
        logic [W-1:0] q, r;
        logic dz, da;
        int lat, bc;
        bit un;
        tbl[0] = '{16'd100,    16'd7,      16'd14,     16'd2,    1'b0};
        tbl[1] = '{16'hFFFF,   16'h0001,   16'hFFFF,   16'd0,    1'b0};
        tbl[2] = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,    1'b0};
        tbl[3] = '{16'd5,      16'd9,      16'd0,      16'd5,    1'b0};
        tbl[4] = '{16'd0,      16'd3,      16'd0,      16'd0,    1'b0};
        tbl[5] = '{16'd1234,   16'd0,      16'hFFFF,   16'd1234, 1'b1};
        tbl[6] = '{16'd1000,   16'd10,     16'd100,    16'd0,    1'b0};
        for (int i = 0; i < 7; i++) begin
            do_div(tbl[i].a, tbl[i].b, q, r, dz, lat, bc, un, da);
            checks++;
            if (q !== tbl[i].q || r !== tbl[i].r || dz !== tbl[i].dz) begin
                errors++;
                $display("FAIL directed_result[%0d]: q=%0h r=%0h dz=%0b, required q=%0h r=%0h dz=%0b",
                         i, q, r, dz, tbl[i].q, tbl[i].r, tbl[i].dz);
            end
            checks++;
            if (lat !== (tbl[i].dz ? 0 : 32) || bc !== (tbl[i].dz ? 1 : 33)) begin
                errors++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d, required %0d and %0d",
                         i, lat, bc, tbl[i].dz ? 0 : 32, tbl[i].dz ? 1 : 33);
            end
            checks++;
            if (un || da !== 1'b0) begin
                errors++;
                $display("FAIL directed_stable[%0d]: unstable=%0b done_after=%0b, required 0 and 0",
                         i, un, da);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [W-1:0] q, r;
        logic dz, da;
        int lat, bc;
        bit un, seen, stray;
        // First run with start pulses fired while busy.
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (c == 5 || c == 20) begin
                start = 1'b1; dividend = 16'd50; divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!seen || quotient !== 16'd100 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL busy_start_ignored: done_seen=%0b q=%0d r=%0d, required 1, 100, 0",
                     seen, quotient, remainder);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: busy=%0b after done, required 0", busy);
        end
        // Second run, reset asynchronously in the middle.
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== {(2*W+3){1'b0}}) begin
            errors++;
            $display("FAIL mid_reset_async: q=%0h r=%0h busy=%0b done=%0b dz=%0b, required all zero",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL mid_reset_no_done: activity after reset=%0b, required 0", stray);
        end
        do_div(16'd50, 16'd5, q, r, dz, lat, bc, un, da);
        checks++;
        if (q !== 16'd10 || r !== 16'd0 || dz !== 1'b0 || lat !== 32) begin
            errors++;
            $display("FAIL after_reset_div: q=%0d r=%0d dz=%0b lat=%0d, required 10 0 0 32",
                     q, r, dz, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dz, edz, da;
        int lat, bc, elat, ebc;
        bit un;
        for (int n = 0; n < 2000; n++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 19) == 0) ? '0 : W'($urandom);
            if (n == 0) begin a = 16'hFFFF; b = 16'h0003; end
            ref_div(a, b, eq, er, edz, elat, ebc);
            do_div(a, b, q, r, dz, lat, bc, un, da);
            checks++;
            if (q !== eq || r !== er || dz !== edz) begin
                errors++;
                $display("FAIL random_result[%0d]: %0h/%0h gave q=%0h r=%0h dz=%0b, required q=%0h r=%0h dz=%0b",
                         n, a, b, q, r, dz, eq, er, edz);
            end
            checks++;
            if (lat !== elat || bc !== ebc) begin
                errors++;
                $display("FAIL random_timing[%0d]: latency=%0d busy_cycles=%0d, required %0d and %0d",
                         n, lat, bc, elat, ebc);
            end
            checks++;
            if (un || da !== 1'b0) begin
                errors++;
                $display("FAIL random_stable[%0d]: unstable=%0b done_after=%0b, required 0 and 0",
                         n, un, da);
            end
            if (b != 0) begin
                checks++;
                if ((32'(q) * 32'(b) + 32'(r)) !== 32'(a) || r >= b) begin
                    errors++;
                    $display("FAIL random_invariant[%0d]: q*b+r=%0d dividend=%0d r=%0d b=%0d",
                             n, 32'(q) * 32'(b) + 32'(r), a, r, b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
